// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit to datapath bundle; master is the control FSM, slave the datapath side.
interface multicycle_control_if #(parameter int COUNT_W = 16);
   logic [31:0]        Instr;
   logic [3:0]         Cond;
   logic               NextPC;
   logic               IRWrite;
   logic               AdrSrc;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUControl;
   logic               RegW;
   logic               MemW;
   logic               Branch;
   logic               PCS;
   logic [1:0]         FlagW;
   logic               Undef;
   logic [COUNT_W-1:0] InstrCount;

   modport master (
      input  Instr,
      output Cond, NextPC, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             RegW, MemW, Branch, PCS, FlagW, Undef, InstrCount
   );

   modport slave (
      output Instr,
      input  Cond, NextPC, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             RegW, MemW, Branch, PCS, FlagW, Undef, InstrCount
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle ARM main decoder producing raw, unconditioned control strobes.
module multicycle_control_fsm #(parameter int COUNT_W = 16) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
   } state_t;

   typedef struct packed {
      logic       nextPC;
      logic       irWrite;
      logic       adrSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic [1:0] aluControl;
      logic       regW;
      logic       memW;
      logic       branch;
      logic [1:0] flagW;
      logic       undef;
   } ctrl_t;

   state_t             state, nextState;
   logic [1:0]         op, nextOp;
   logic [5:0]         funct, nextFunct;
   logic [3:0]         rd, cond;
   logic [COUNT_W-1:0] instrCount;
   ctrl_t              ctrl, ctrlOut;
   logic               unusedInstrBits;

   // Moore output table; evaluated for the state being entered so the outputs come straight from flops.
   function automatic ctrl_t ctrlFor(state_t s, logic [1:0] o, logic [5:0] f);
      ctrl_t      c;
      logic       cmp;
      logic [1:0] alu;
      cmp = f[4:1] == 4'b1010;
      alu = (f[4:1] == 4'b0010 || cmp) ? 2'b01 :
            f[4:1] == 4'b0000          ? 2'b10 :
            f[4:1] == 4'b1100          ? 2'b11 : 2'b00;
      c = '0;
      case (s)
         FETCH: begin
            c.nextPC    = 1'b1;
            c.irWrite   = 1'b1;
            c.aluSrcA   = 1'b1;
            c.aluSrcB   = 2'b10;
            c.resultSrc = 2'b10;
         end
         DECODE: begin
            c.aluSrcA   = 1'b1;
            c.aluSrcB   = 2'b10;
            c.resultSrc = 2'b10;
            c.undef     = o == 2'b11;
         end
         MEMADR:   c.aluSrcB = 2'b01;
         MEMREAD:  c.adrSrc = 1'b1;
         MEMWB: begin
            c.resultSrc = 2'b01;
            c.regW      = 1'b1;
         end
         MEMWRITE: begin
            c.adrSrc = 1'b1;
            c.memW   = 1'b1;
         end
         EXECUTER, EXECUTEI: begin
            c.aluSrcB    = s == EXECUTEI ? 2'b01 : 2'b00;
            c.aluControl = alu;
            c.flagW      = cmp ? 2'b11 : {f[0], f[0] & ~alu[1]};
         end
         ALUWB:    c.regW = ~cmp;
         BRANCH: begin
            c.aluSrcB   = 2'b01;
            c.resultSrc = 2'b10;
            c.branch    = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // Next-state selection; instruction fields are taken live from Instr only while leaving FETCH.
   always_comb begin
      nextOp    = state == FETCH ? bus.Instr[27:26] : op;
      nextFunct = state == FETCH ? bus.Instr[25:20] : funct;
      nextState = FETCH;
      case (state)
         FETCH:              nextState = DECODE;
         DECODE:             nextState = op == 2'b00 ? (funct[5] ? EXECUTEI : EXECUTER) :
                                         op == 2'b01 ? MEMADR :
                                         op == 2'b10 ? BRANCH : FETCH;
         MEMADR:             nextState = funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:            nextState = MEMWB;
         EXECUTER, EXECUTEI: nextState = ALUWB;
         default:            nextState = FETCH;
      endcase
   end

   // State, latched instruction fields, decoded-instruction counter and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FETCH;
         op         <= '0;
         funct      <= '0;
         rd         <= '0;
         cond       <= '0;
         instrCount <= '0;
         ctrl       <= ctrlFor(FETCH, 2'b00, 6'b0);
      end else begin
         state <= nextState;
         op    <= nextOp;
         funct <= nextFunct;
         ctrl  <= ctrlFor(nextState, nextOp, nextFunct);
         if (state == FETCH) begin
            rd   <= bus.Instr[15:12];
            cond <= bus.Instr[31:28];
         end
         if (state == DECODE) instrCount <= instrCount + 1'b1;
      end
   end

   // Reset gates every output immediately so a strobe cannot commit in the cycle reset is asserted.
   assign ctrlOut         = rst_n ? ctrl : '0;
   assign bus.Cond        = rst_n ? cond : '0;
   assign bus.InstrCount  = rst_n ? instrCount : '0;
   assign bus.NextPC      = ctrlOut.nextPC;
   assign bus.IRWrite     = ctrlOut.irWrite;
   assign bus.AdrSrc      = ctrlOut.adrSrc;
   assign bus.ALUSrcA     = ctrlOut.aluSrcA;
   assign bus.ALUSrcB     = ctrlOut.aluSrcB;
   assign bus.ResultSrc   = ctrlOut.resultSrc;
   assign bus.ALUControl  = ctrlOut.aluControl;
   assign bus.RegW        = ctrlOut.regW;
   assign bus.MemW        = ctrlOut.memW;
   assign bus.Branch      = ctrlOut.branch;
   assign bus.FlagW       = ctrlOut.flagW;
   assign bus.Undef       = ctrlOut.undef;
   assign bus.PCS         = (ctrlOut.regW & (rd == 4'hF)) | ctrlOut.branch;
   assign unusedInstrBits = ^{bus.Instr[19:16], bus.Instr[11:0]};
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction stream checked cycle by cycle against an instruction-level model.
module tb_multicycle_control_fsm;
   localparam int CW = 4;

   typedef struct {
      int          cyc;
      logic [24:0] v;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   int            tests = 0;
   int            fails = 0;
   int            cycNo = 0;
   exp_t          expQ[$];
   logic [24:0]   hist[int];
   logic [3:0]    mCond = '0;
   logic [CW-1:0] mCount = '0;

   multicycle_control_if #(.COUNT_W(CW)) bus();
   multicycle_control_fsm #(.COUNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [16:0] mk(input logic nextPC, input logic irWrite, input logic adrSrc,
                                      input logic aluSrcA, input logic [1:0] aluSrcB,
                                      input logic [1:0] resultSrc, input logic [1:0] alu,
                                      input logic regW, input logic memW, input logic branch,
                                      input logic pcs, input logic [1:0] flagW, input logic undef);
      return {nextPC, irWrite, adrSrc, aluSrcA, aluSrcB, resultSrc, alu, regW, memW, branch, pcs, flagW, undef};
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic [16:0] c);
      bus.Instr = ins;
      expQ.push_back(exp_t'{cycNo, {mCond, c, mCount}});
      cycNo++;
      @(posedge clk); #1;
   endtask

   task automatic stepRst();
      rst_n = 1'b0;
      bus.Instr = $urandom;
      expQ.push_back(exp_t'{cycNo, 25'b0});
      cycNo++;
      @(posedge clk); #1;
   endtask

   task automatic release_rst();
      rst_n = 1'b1;
      mCond = '0;
      mCount = '0;
   endtask

   // Whole-instruction model: the cycle-by-cycle output sequence an instruction must produce.
   task automatic runInstr(input logic [31:0] ins);
      logic [1:0] op = ins[27:26];
      logic [5:0] funct = ins[25:20];
      logic       rd15 = ins[15:12] == 4'hF;
      logic       cmp = funct[4:1] == 4'b1010;
      logic [1:0] alu;
      logic [1:0] flagW;
      case (funct[4:1])
         4'b0010, 4'b1010: alu = 2'd1;
         4'b0000:          alu = 2'd2;
         4'b1100:          alu = 2'd3;
         default:          alu = 2'd0;
      endcase
      flagW = cmp ? 2'b11 : {funct[0], funct[0] && alu <= 2'd1};
      step(ins, mk(1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      mCond = ins[31:28];
      step($urandom, mk(0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, op == 2'b11));
      mCount++;
      if (op == 2'b01) begin
         step($urandom, mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
         if (funct[0]) begin
            step($urandom, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            step($urandom, mk(0, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0, rd15, 0, 0));
         end else
            step($urandom, mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end else if (op == 2'b10)
         step($urandom, mk(0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 1, 0, 0));
      else if (op == 2'b00) begin
         step($urandom, mk(0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, 0, alu, 0, 0, 0, 0, flagW, 0));
         step($urandom, mk(0, 0, 0, 0, 0, 0, 0, !cmp, 0, 0, !cmp && rd15, 0, 0));
      end
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] r = $urandom;
      logic [3:0]  known[5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      logic [3:0]  unknown[4] = '{4'b0001, 4'b0011, 4'b1000, 4'b1111};
      if (r[27:26] == 2'b00) begin
         if ($urandom_range(0, 4) == 0) begin
            r[24:21] = unknown[$urandom_range(0, 3)];
            r[20] = 1'b0;
         end else
            r[24:21] = known[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
      return r;
   endfunction

   // Single compare point, mid-cycle, against the model's expectation for that cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t        e;
         logic [24:0] got;
         e = expQ.pop_front();
         got = {bus.Cond, bus.NextPC, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.ALUControl, bus.RegW, bus.MemW, bus.Branch, bus.PCS, bus.FlagW, bus.Undef, bus.InstrCount};
         hist[e.cyc] = got;
         tests++;
         if (got !== e.v) begin
            fails++;
            $display("FAIL cycle %0d outputs: got %h, expected %h", e.cyc, got, e.v);
         end
      end
   end

   initial begin
      int          c, c2;
      logic [24:0] h;
      bus.Instr = '0;
      @(posedge clk); #1;
      stepRst();
      stepRst();
      release_rst();
      // ADDS R1,R2,R3
      c = cycNo;
      runInstr(32'hE0921003);
      h = hist[c + 2];
      chk("adds exec alucontrol", h[12:11], 8'h0);
      chk("adds exec flagw", h[6:5], 8'h3);
      h = hist[c + 3];
      chk("adds aluwb regw", h[10], 8'h1);
      chk("adds aluwb pcs", h[7], 8'h0);
      chk("adds aluwb cond", h[24:21], 8'hE);
      // LDR R15,[R0,#4]
      c = cycNo;
      runInstr(32'hE590F004);
      h = hist[c + 4];
      chk("ldr memwb regw", h[10], 8'h1);
      chk("ldr memwb pcs", h[7], 8'h1);
      // STR R1,[R0,#4]
      c = cycNo;
      runInstr(32'hE5801004);
      h = hist[c + 2];
      chk("str memadr memw", h[9], 8'h0);
      h = hist[c + 3];
      chk("str memwrite memw", h[9], 8'h1);
      // CMP R0,#0
      c2 = cycNo;
      runInstr(32'hE3500000);
      h = hist[c + 4];
      chk("str 4-cycle return irwrite", h[19], 8'h1);
      h = hist[c2 + 2];
      chk("cmp exec alucontrol", h[12:11], 8'h1);
      chk("cmp exec flagw", h[6:5], 8'h3);
      h = hist[c2 + 3];
      chk("cmp aluwb regw", h[10], 8'h0);
      // BEQ
      c = cycNo;
      runInstr(32'h0A000002);
      h = hist[c + 2];
      chk("beq branch", h[8], 8'h1);
      chk("beq pcs", h[7], 8'h1);
      chk("beq cond", h[24:21], 8'h0);
      // Undefined opcode
      c2 = cycNo;
      runInstr(32'hEC000000);
      h = hist[c + 3];
      chk("beq 3-cycle return irwrite", h[19], 8'h1);
      h = hist[c2 + 1];
      chk("undef flag", h[4], 8'h1);
      chk("undef strobes", {h[10:9], h[6:5]}, 8'h0);
      // STR aborted by reset in MEMWRITE
      c = cycNo;
      step(32'hE5801004, mk(1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      mCond = 4'hE;
      step($urandom, mk(0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      mCount++;
      step($urandom, mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      stepRst();
      release_rst();
      h = hist[c];
      chk("count after undef", h[3:0], 8'h6);
      h = hist[c + 3];
      chk("reset in memwrite memw", h[9], 8'h0);
      // Wrap: 16 instructions after reset brings InstrCount back to 0
      c2 = cycNo;
      for (int i = 0; i < 16; i++) runInstr(randInstr());
      h = hist[c2];
      chk("fetch after reset irwrite/nextpc", h[20:19], 8'h3);
      c = cycNo;
      runInstr(randInstr());
      h = hist[c];
      chk("count wrap", h[3:0], 8'h0);
      // Random stream with occasional resets at instruction boundaries
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            stepRst();
            release_rst();
         end
         runInstr(randInstr());
      end
      @(negedge clk); #1;
      chk("expectation queue drained", 8'(expQ.size()), 8'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
